// File: rtl/me_mb_scheduler_if.sv
// Bus bundle between the ME macroblock scheduler and its environment:
// frame control, the ME core handshake and the result stream.
// When ME_SCHED_TOTAL_SAD_EN is defined the bundle also carries the frame SAD total.
interface me_mb_scheduler_if;
    logic        start_i;
    logic        abort_i;
    logic        busy_o;
    logic        done_o;
    logic        me_rst_o;
    logic        me_en_o;
    logic        me_valid_i;
    logic [13:0] me_sad_i;
    logic [4:0]  me_row_i;
    logic [4:0]  me_col_i;
    logic [7:0]  mb_x_o;
    logic [7:0]  mb_y_o;
    logic [31:0] cur_base_o;
    logic [31:0] ref_base_o;
    logic        mv_valid_o;
    logic        mv_ready_i;
    logic [45:0] mv_data_o;
`ifdef ME_SCHED_TOTAL_SAD_EN
    logic [23:0] sched_sad_total_o;
`endif

    // scheduler side
    modport master (
        input  start_i, abort_i, me_valid_i, me_sad_i, me_row_i, me_col_i, mv_ready_i,
        output busy_o, done_o, me_rst_o, me_en_o, mb_x_o, mb_y_o,
        output cur_base_o, ref_base_o, mv_valid_o, mv_data_o
`ifdef ME_SCHED_TOTAL_SAD_EN
        , output sched_sad_total_o
`endif
    );

    // frame control / ME core / consumer side
    modport slave (
        output start_i, abort_i, me_valid_i, me_sad_i, me_row_i, me_col_i, mv_ready_i,
        input  busy_o, done_o, me_rst_o, me_en_o, mb_x_o, mb_y_o,
        input  cur_base_o, ref_base_o, mv_valid_o, mv_data_o
`ifdef ME_SCHED_TOTAL_SAD_EN
        , input sched_sad_total_o
`endif
    );
endinterface

// File: rtl/me_mb_scheduler.sv
// Frame-level sequencer for the ME core: walks the macroblock grid in raster
// order, restarts/enables the ME core per macroblock and queues each result
// in a small FIFO drained by valid/ready.
// Optional: define ME_SCHED_TOTAL_SAD_EN to add a saturating frame SAD sum
// on sched_sad_total_o.
//
// state  | meaning
// IDLE   | waiting for start_i
// WAITQ  | waiting for a free FIFO slot before launching the next MB
// LAUNCH | one-cycle synchronous restart of the ME core
// RUN    | ME core enabled, waiting for its data_valid
// STORE  | push captured result, advance raster or finish the frame
module me_mb_scheduler #(
    parameter int MB_COLS    = 4,
    parameter int MB_ROWS    = 4,
    parameter int CUR_STRIDE = 64,
    parameter int REF_STRIDE = 256,
    parameter int FIFO_DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    me_mb_scheduler_if.master bus
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAITQ,
        S_LAUNCH,
        S_RUN,
        S_STORE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [7:0]    mb_x;
    logic [7:0]    mb_y;
    logic [13:0]   cap_sad;
    logic [4:0]    cap_row;
    logic [4:0]    cap_col;
    logic [45:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] fifo_cnt;
    logic [31:0]   mb_idx;
    logic [45:0]   entry;
    logic          last_mb;
    logic          start_ok;
    logic          push;
    logic          pop;

    assign last_mb  = (mb_x == 8'(MB_COLS - 1)) && (mb_y == 8'(MB_ROWS - 1));
    assign start_ok = (state == S_IDLE) && bus.start_i && !bus.abort_i;
    // an abort in STORE flushes the FIFO anyway, so the push is suppressed
    assign push     = (state == S_STORE) && !bus.abort_i;
    assign pop      = (fifo_cnt != '0) && bus.mv_ready_i;
    assign entry    = {mb_y, mb_x, cap_sad, 3'b000, cap_row, 3'b000, cap_col};

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // next-state logic; abort overrides every transition
    always_comb begin
        state_nxt = state;
        if (bus.abort_i) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:   if (bus.start_i) state_nxt = S_WAITQ;
                S_WAITQ:  if (fifo_cnt < CW'(FIFO_DEPTH)) state_nxt = S_LAUNCH;
                S_LAUNCH: state_nxt = S_RUN;
                S_RUN:    if (bus.me_valid_i) state_nxt = S_STORE;
                S_STORE:  state_nxt = last_mb ? S_IDLE : S_WAITQ;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    // Moore-style control outputs decoded from the current state
    always_comb begin
        bus.busy_o   = (state != S_IDLE);
        bus.me_rst_o = (state == S_LAUNCH);
        bus.me_en_o  = (state == S_RUN);
        bus.done_o   = (state == S_STORE) && last_mb && !bus.abort_i;
    end

    // raster position: cleared on start, advanced after each non-final push
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mb_x <= '0;
            mb_y <= '0;
        end else if (start_ok) begin
            mb_x <= '0;
            mb_y <= '0;
        end else if (push && !last_mb) begin
            if (mb_x == 8'(MB_COLS - 1)) begin
                mb_x <= '0;
                mb_y <= mb_y + 8'd1;
            end else begin
                mb_x <= mb_x + 8'd1;
            end
        end
    end

    // capture the ME result on data_valid while running
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_sad <= '0;
            cap_row <= '0;
            cap_col <= '0;
        end else if ((state == S_RUN) && bus.me_valid_i && !bus.abort_i) begin
            cap_sad <= bus.me_sad_i;
            cap_row <= bus.me_row_i;
            cap_col <= bus.me_col_i;
        end
    end

    // result FIFO; abort flushes it, start deliberately does not
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
        end else if (bus.abort_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= entry;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    assign mb_idx         = {24'd0, mb_y} * 32'(MB_COLS) + {24'd0, mb_x};
    assign bus.cur_base_o = mb_idx * 32'(CUR_STRIDE);
    assign bus.ref_base_o = mb_idx * 32'(REF_STRIDE);
    assign bus.mb_x_o     = mb_x;
    assign bus.mb_y_o     = mb_y;
    assign bus.mv_valid_o = (fifo_cnt != '0);
    assign bus.mv_data_o  = fifo_mem[rd_ptr];

`ifdef ME_SCHED_TOTAL_SAD_EN
    logic [23:0] sad_total;
    logic [24:0] sad_sum;

    assign sad_sum = {1'b0, sad_total} + {11'd0, cap_sad};

    // saturating frame SAD accumulator, summed as each result is pushed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sad_total <= '0;
        end else if (bus.abort_i || start_ok) begin
            sad_total <= '0;
        end else if (push) begin
            sad_total <= sad_sum[24] ? 24'hFFFFFF : sad_sum[23:0];
        end
    end

    assign bus.sched_sad_total_o = sad_total;
`endif

endmodule

// File: tb/tb_me_mb_scheduler.sv
// Directed bench for me_mb_scheduler on a 2x2 grid with a 2-entry FIFO.
// A small ME model answers 10 enabled cycles after each restart with
// sad = seed + k, row = k+1, col = k+3 (k = raster index of the MB).
module tb_me_mb_scheduler;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    me_mb_scheduler_if bus();

    me_mb_scheduler #(
        .MB_COLS(2), .MB_ROWS(2), .CUR_STRIDE(64), .REF_STRIDE(256), .FIFO_DEPTH(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    int n_vec  = 0;
    int n_fail = 0;

    int   me_cnt      = 0;
    logic model_v     = 1'b0;
    logic inj_v       = 1'b0;
    int   sad_seed    = 100;
    logic sad_fixed   = 1'b0;
    int   rst_pulses  = 0;
    int   done_pulses = 0;
    int   k_mb;
    logic [45:0] got_q [$];
    logic [31:0] cur_q [$];
    logic [31:0] ref_q [$];

    assign k_mb           = int'(bus.mb_y_o) * 2 + int'(bus.mb_x_o);
    assign bus.me_valid_i = model_v | inj_v;
    assign bus.me_sad_i   = sad_fixed ? 14'h3FFF : 14'(sad_seed + k_mb);
    assign bus.me_row_i   = 5'(k_mb + 1);
    assign bus.me_col_i   = 5'(k_mb + 3);

    // ME core model, pulse counters and result collector, all on the falling edge
    always @(negedge clk) begin
        if (bus.me_rst_o) begin
            me_cnt  = 0;
            model_v = 1'b0;
            rst_pulses++;
            cur_q.push_back(bus.cur_base_o);
            ref_q.push_back(bus.ref_base_o);
        end else if (bus.me_en_o) begin
            me_cnt++;
            model_v = (me_cnt == 10);
        end else begin
            model_v = 1'b0;
        end
        if (bus.done_o) done_pulses++;
        if (bus.mv_valid_o && bus.mv_ready_i) got_q.push_back(bus.mv_data_o);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [45:0] ent(int y, int x, int sad, int row, int col);
        return {8'(y), 8'(x), 14'(sad), 8'(row), 8'(col)};
    endfunction

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        bus.start_i = 1'b1;
        tick(1);
        bus.start_i = 1'b0;
    endtask

    task automatic wait_done(string tag, int budget);
        int d0 = done_pulses;
        int n  = 0;
        while (done_pulses == d0 && n < budget) begin
            tick(1);
            n++;
        end
        check(tag, 64'(done_pulses != d0), 64'd1);
    endtask

    task automatic wait_run_x(string tag, logic [7:0] x, int budget);
        int n = 0;
        while (!(bus.me_en_o && bus.mb_x_o == x) && n < budget) begin
            tick(1);
            n++;
        end
        check(tag, 64'(bus.me_en_o && bus.mb_x_o == x), 64'd1);
    endtask

    task automatic check_frame(string tag, int b);
        check({tag, "_count"}, 64'(got_q.size() - b), 64'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("%s_entry%0d", tag, i), 64'(got_q[b + i]),
                  64'(ent(i / 2, i % 2, 100 + i, i + 1, i + 3)));
    endtask

    initial begin
        int b;
        int c0;
        int r0;
        int d0;

        rst           = 1'b1;
        bus.start_i   = 1'b0;
        bus.abort_i   = 1'b0;
        bus.mv_ready_i = 1'b1;
        tick(2);

        // reset values
        check("rst_busy",     64'(bus.busy_o),     64'd0);
        check("rst_done",     64'(bus.done_o),     64'd0);
        check("rst_me_en",    64'(bus.me_en_o),    64'd0);
        check("rst_me_rst",   64'(bus.me_rst_o),   64'd0);
        check("rst_mv_valid", 64'(bus.mv_valid_o), 64'd0);
        check("rst_mv_data",  64'(bus.mv_data_o),  64'd0);
        check("rst_mb_x",     64'(bus.mb_x_o),     64'd0);
        check("rst_mb_y",     64'(bus.mb_y_o),     64'd0);
        check("rst_cur_base", 64'(bus.cur_base_o), 64'd0);
        check("rst_ref_base", 64'(bus.ref_base_o), 64'd0);
        rst = 1'b0;
        tick(1);

        // full frame with consumer always ready
        b  = got_q.size();
        c0 = cur_q.size();
        d0 = done_pulses;
        pulse_start();
        check("f1_busy_waitq", 64'(bus.busy_o),   64'd1);
        check("f1_waitq_rst",  64'(bus.me_rst_o), 64'd0);
        tick(1);
        check("f1_launch_rst", 64'(bus.me_rst_o), 64'd1);
        check("f1_launch_en",  64'(bus.me_en_o),  64'd0);
        tick(1);
        check("f1_run_en",     64'(bus.me_en_o),  64'd1);
        check("f1_run_rst",    64'(bus.me_rst_o), 64'd0);
        wait_done("f1_done_seen", 200);
        check("f1_busy_after", 64'(bus.busy_o), 64'd0);
        tick(3);
        check_frame("f1", b);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("f1_cur_base%0d", i), 64'(cur_q[c0 + i]), 64'(i * 64));
            check($sformatf("f1_ref_base%0d", i), 64'(ref_q[c0 + i]), 64'(i * 256));
        end
        check("f1_done_pulses", 64'(done_pulses - d0), 64'd1);
        check("f1_fifo_empty",  64'(bus.mv_valid_o),   64'd0);

        // backpressure: consumer stalled, FIFO fills and scheduler parks
        bus.mv_ready_i = 1'b0;
        b  = got_q.size();
        r0 = rst_pulses;
        d0 = done_pulses;
        pulse_start();
        tick(60);
        check("bp_launches",  64'(rst_pulses - r0),  64'd2);
        check("bp_me_en",     64'(bus.me_en_o),      64'd0);
        check("bp_busy",      64'(bus.busy_o),       64'd1);
        check("bp_mv_valid",  64'(bus.mv_valid_o),   64'd1);
        check("bp_head_hold", 64'(bus.mv_data_o),    64'(ent(0, 0, 100, 1, 3)));
        check("bp_no_pops",   64'(got_q.size() - b), 64'd0);
        bus.mv_ready_i = 1'b1;
        wait_done("bp_done_seen", 200);
        tick(3);
        check_frame("bp", b);
        check("bp_done_pulses", 64'(done_pulses - d0), 64'd1);

        // abort during RUN of MB (1,0), then restart from (0,0)
        d0 = done_pulses;
        pulse_start();
        wait_run_x("ab_reach_mb1", 8'd1, 100);
        tick(3);
        bus.abort_i = 1'b1;
        tick(1);
        bus.abort_i = 1'b0;
        check("ab_busy",     64'(bus.busy_o),     64'd0);
        check("ab_mv_valid", 64'(bus.mv_valid_o), 64'd0);
        check("ab_me_en",    64'(bus.me_en_o),    64'd0);
        tick(20);
        check("ab_no_done",  64'(done_pulses - d0), 64'd0);
        b = got_q.size();
        pulse_start();
        check("ab_restart_x", 64'(bus.mb_x_o), 64'd0);
        check("ab_restart_y", 64'(bus.mb_y_o), 64'd0);
        wait_done("ab_done_seen", 200);
        tick(3);
        check_frame("ab", b);

        // start pulsed while running is ignored
        b  = got_q.size();
        r0 = rst_pulses;
        d0 = done_pulses;
        pulse_start();
        wait_run_x("st_reach_run", 8'd0, 50);
        pulse_start();
        wait_done("st_done_seen", 200);
        tick(3);
        check("st_results",  64'(got_q.size() - b),  64'd4);
        check("st_launches", 64'(rst_pulses - r0),   64'd4);
        check("st_done",     64'(done_pulses - d0),  64'd1);

        // stray data_valid in IDLE and in WAITQ must not push
        b = got_q.size();
        inj_v = 1'b1;
        tick(1);
        inj_v = 1'b0;
        tick(3);
        check("sv_idle_valid", 64'(bus.mv_valid_o),   64'd0);
        check("sv_idle_count", 64'(got_q.size() - b), 64'd0);
        pulse_start();
        inj_v = 1'b1;
        tick(1);
        inj_v = 1'b0;
        check("sv_waitq_to_launch", 64'(bus.me_rst_o), 64'd1);
        wait_done("sv_done_seen", 200);
        tick(3);
        check_frame("sv", b);

        // asynchronous reset mid-frame
        pulse_start();
        tick(20);
        rst = 1'b1;
        #1;
        check("mr_busy",     64'(bus.busy_o),     64'd0);
        check("mr_me_en",    64'(bus.me_en_o),    64'd0);
        check("mr_mv_valid", 64'(bus.mv_valid_o), 64'd0);
        check("mr_mb_x",     64'(bus.mb_x_o),     64'd0);
        tick(2);
        rst = 1'b0;
        tick(1);

`ifdef ME_SCHED_TOTAL_SAD_EN
        // frame SAD total: 4 x 16383 = 65532, next frame 100+101+102+103 = 406
        check("ts_after_rst", 64'(bus.sched_sad_total_o), 64'd0);
        sad_fixed = 1'b1;
        pulse_start();
        wait_done("ts1_done_seen", 200);
        tick(3);
        check("ts1_total", 64'(bus.sched_sad_total_o), 64'd65532);
        tick(5);
        check("ts1_hold",  64'(bus.sched_sad_total_o), 64'd65532);
        sad_fixed = 1'b0;
        pulse_start();
        check("ts2_cleared", 64'(bus.sched_sad_total_o), 64'd0);
        wait_done("ts2_done_seen", 200);
        tick(3);
        check("ts2_total", 64'(bus.sched_sad_total_o), 64'd406);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/me_mb_scheduler.md
Name: me_mb_scheduler

Overview:
Frame-level sequencer for the ME core. Walks a MB_COLS x MB_ROWS grid of macroblocks in raster order, and for each one:
- presents cur/ref memory base addresses,
- restarts and enables the ME core,
- waits for its data_valid,
- pushes {mb position, MSAD, MSAD_row, MSAD_column} into an internal result FIFO, drained via valid/ready.

Sits between the top-level frame control and the ME instance, which adds cur_base_o/ref_base_o to its local addresses.

Parameters:
MB_COLS, 4, macroblocks per row (1..255)
MB_ROWS, 4, macroblock rows per frame (1..255)
CUR_STRIDE, 64, cur-memory words per macroblock
REF_STRIDE, 256, ref-memory words per macroblock search window
FIFO_DEPTH, 4, result FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start_i  in  1  frame start pulse; sampled only in IDLE
abort_i  in  1  abort frame; highest priority after rst
busy_o  out  1  high from accepted start until done_o cycle inclusive
done_o  out  1  one-cycle pulse when last MB result is pushed
me_rst_o  out  1  synchronous restart to ME core, one cycle per MB
me_en_o  out  1  ME enable (drives en_i)
me_valid_i  in  1  ME data_valid
me_sad_i  in  14  ME MSAD
me_row_i  in  5  ME MSAD_row
me_col_i  in  5  ME MSAD_column
mb_x_o  out  8  current MB column
mb_y_o  out  8  current MB row
cur_base_o  out  32  (mb_y*MB_COLS+mb_x)*CUR_STRIDE
ref_base_o  out  32  (mb_y*MB_COLS+mb_x)*REF_STRIDE
mv_valid_o  out  1  FIFO non-empty
mv_ready_i  in  1  consumer ready
mv_data_o  out  46  {mb_y[45:38], mb_x[37:30], sad[29:16], row[15:8] zero-extended, col[7:0] zero-extended}
sched_sad_total_o  out  24  frame SAD sum; present only with macro

Behaviour:
- Reset values: all outputs 0; state IDLE; FIFO empty; mb_x=mb_y=0.
- IDLE:
  - start_i=1 -> clear mb_x/mb_y, busy_o=1, go to WAITQ.
  - FIFO is NOT flushed by start; residual entries still drain.
- WAITQ: FIFO count < FIFO_DEPTH -> LAUNCH; else stay (backpressure, me_en_o=0).
- LAUNCH: me_rst_o=1 for exactly one cycle, me_en_o=0 -> RUN.
- RUN:
  - me_en_o=1.
  - me_valid_i=1 -> register sad/row/col, me_en_o drops next cycle -> STORE.
  - me_valid_i outside RUN is ignored.
- STORE:
  - Push one entry; space is guaranteed because at most one result is in flight and WAITQ gated entry.
  - If last MB (mb_x=MB_COLS-1 and mb_y=MB_ROWS-1): done_o=1 -> IDLE, busy_o falls next cycle.
  - Else advance raster: mb_x+1; wrap to 0 with mb_y+1 at MB_COLS-1. -> WAITQ.
- Bases are combinational from the mb_x/mb_y registers, 32-bit unsigned, and stable from LAUNCH through STORE.
- FIFO:
  - Pop when mv_valid_o and mv_ready_i.
  - mv_valid_o rises the cycle after the STORE that pushes into an empty FIFO.
  - Simultaneous push and pop leaves count unchanged.
  - mv_data_o is stable while mv_valid_o=1 and mv_ready_i=0.
- abort_i (any state):
  - Next cycle: IDLE, FIFO flushed, me_en_o=0, busy_o=0.
  - No done_o.
  - abort_i together with start_i in IDLE: abort wins.
- start_i while busy: ignored.
- rst mid-frame: immediate return to reset values.
- Minimum per-MB overhead: WAITQ+LAUNCH+STORE = 3 cycles beyond the ME latency.

Optional Feature:
Macro ME_SCHED_TOTAL_SAD_EN.
- Defined:
  - sched_sad_total_o exists.
  - Cleared on accepted start_i; adds zero-extended me_sad_i in each STORE.
  - Saturates at 24'hFFFFFF; holds after done_o until next start.
  - Cleared by abort and rst.
- Undefined: port and accumulator are absent.

Test Plan:
- MB_COLS=2, MB_ROWS=2, ME model returns valid 10 cycles after en with sad=100+k, mv_ready_i=1 -> 4 entries in order (0,0),(1,0),(0,1),(1,1); cur_base 0,64,128,192; done_o single pulse after 4th push.
- Same grid, mv_ready_i=0 throughout, FIFO_DEPTH=2 -> 2 entries pushed, scheduler parks in WAITQ with me_en_o=0; raising mv_ready_i resumes, all 4 delivered, none lost or duplicated.
- abort_i asserted during RUN of MB (1,0) -> next cycle busy_o=0, mv_valid_o=0, no done_o; a subsequent start_i restarts at (0,0).
- start_i pulsed during RUN -> ignored; exactly MB_COLS*MB_ROWS results; me_rst_o pulses exactly 4 times.
- me_valid_i pulsed in IDLE and in WAITQ -> no FIFO push.
- ME_SCHED_TOTAL_SAD_EN defined, SADs 16383 x4 -> total 65532; second frame restarts the sum from 0.
